// File: rtl/scntl_to_simd_result_tx_pkg.sv
// Shared constants for the scntl -> SIMD lane-result path.
// Lane geometry mirrors the PE exec-lane defines; FSM state encodings.
package scntl_to_simd_result_tx_pkg;

  localparam int PE_NUM_OF_EXEC_LANES = 32;
  localparam int PE_EXEC_LANE_WIDTH   = 32;
  localparam int SCNTL_FIFO_DEPTH     = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

endpackage

// File: rtl/scntl_result_lane_fifo.sv
// Per-lane result FIFO with count/full/empty and fall-through head.
// Ports: clk, rst, push/push_data, pop, head, full, empty.
module scntl_result_lane_fifo
  import scntl_to_simd_result_tx_pkg::*;
#(
  parameter int WIDTH = PE_EXEC_LANE_WIDTH,
  parameter int DEPTH = SCNTL_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             bypass;
  logic             wr_en;
  logic             rd_en;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Push and pop on an empty FIFO pass the word straight through.
  assign bypass = push & pop & empty;
  assign wr_en  = push & ~bypass;
  assign rd_en  = pop & ~empty;
  assign head   = empty ? push_data : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/scntl_to_simd_result_tx.sv
// Buffers per-lane stOp results and replays them to the SIMD regFile.
// Ports: op control (op_start/enable/busy/complete/error), stOp
// valid/ready/data input, SIMD stall and valid/data output pulses.
// Option SCNTL_TO_SIMD_RESULT_TX_PARITY_EN adds parity in/out ports.
module scntl_to_simd_result_tx
  import scntl_to_simd_result_tx_pkg::*;
#(
  parameter int NUM_LANES  = PE_NUM_OF_EXEC_LANES,
  parameter int LANE_WIDTH = PE_EXEC_LANE_WIDTH,
  parameter int FIFO_DEPTH = SCNTL_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset_poweron,
  input  logic                            op_start,
  input  logic [NUM_LANES-1:0]            op_lane_enable,
  input  logic [NUM_LANES-1:0]            stop_result_valid,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] stop_result_data,
`ifdef SCNTL_TO_SIMD_RESULT_TX_PARITY_EN
  input  logic [NUM_LANES-1:0]            stop_result_parity,
  output logic [NUM_LANES-1:0]            lane_result_parity,
`endif
  output logic [NUM_LANES-1:0]            stop_result_ready,
  input  logic                            simd_stall,
  output logic [NUM_LANES-1:0]            lane_result_valid,
  output logic [NUM_LANES*LANE_WIDTH-1:0] lane_result,
  output logic                            op_busy,
  output logic                            op_complete,
  output logic                            op_error
);

  localparam int W = LANE_WIDTH;

  logic [1:0]                state;
  logic [1:0]                state_nxt;
  logic [NUM_LANES-1:0]      en_mask;
  logic [NUM_LANES-1:0]      rcv_mask;
  logic [NUM_LANES-1:0]      dlv_mask;
  logic [NUM_LANES-1:0]      acc;
  logic [NUM_LANES-1:0]      full;
  logic [NUM_LANES-1:0]      empty;
  logic [NUM_LANES-1:0]      pop;
  logic [NUM_LANES-1:0]      par_err;
  logic [NUM_LANES*W-1:0]    head;
  logic                      start_idle;
  logic                      all_rcv;
  logic                      all_dlv;
  logic                      err_set;

  assign acc        = stop_result_valid & stop_result_ready;
  assign start_idle = op_start && (state == ST_IDLE);
  assign all_rcv    = ((rcv_mask & en_mask) == en_mask);
  assign all_dlv    = ((dlv_mask & en_mask) == en_mask);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    scntl_result_lane_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (reset_poweron),
      .push      (acc[i]),
      .push_data (stop_result_data[i*W +: W]),
      .pop       (pop[i]),
      .head      (head[i*W +: W]),
      .full      (full[i]),
      .empty     (empty[i])
    );

    assign stop_result_ready[i] = ~full[i];
    // An empty lane can still forward a word accepted this cycle.
    assign pop[i] = ~simd_stall & (~empty[i] | acc[i]);

`ifdef SCNTL_TO_SIMD_RESULT_TX_PARITY_EN
    assign par_err[i] = acc[i] &
      ((^stop_result_data[i*W +: W]) != stop_result_parity[i]);
`else
    assign par_err[i] = 1'b0;
`endif
  end

  // A start in IDLE judges same-cycle accepts against the new mask.
  always_comb begin
    err_set = |par_err;
    if (start_idle) begin
      err_set = err_set | (|(acc & ~op_lane_enable));
    end else if (state == ST_IDLE) begin
      err_set = err_set | (|acc);
    end else begin
      err_set = err_set | op_start |
                (|(acc & (~en_mask | rcv_mask)));
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (op_start) state_nxt = ST_COLLECT;
      ST_COLLECT: if (all_rcv)  state_nxt = ST_DRAIN;
      ST_DRAIN:   if (all_dlv)  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    op_busy     = (state != ST_IDLE);
    op_complete = (state == ST_DRAIN) && all_dlv;
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      en_mask  <= '0;
      rcv_mask <= '0;
      dlv_mask <= '0;
      op_error <= 1'b0;
    end else if (start_idle) begin
      en_mask  <= op_lane_enable;
      rcv_mask <= acc;
      dlv_mask <= '0;
      op_error <= err_set;
    end else begin
      if (state != ST_IDLE) begin
        rcv_mask <= rcv_mask | acc;
        dlv_mask <= dlv_mask | lane_result_valid;
      end
      if (err_set) op_error <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      lane_result_valid  <= '0;
      lane_result        <= '0;
`ifdef SCNTL_TO_SIMD_RESULT_TX_PARITY_EN
      lane_result_parity <= '0;
`endif
    end else begin
      lane_result_valid <= pop;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (pop[i]) begin
          lane_result[i*W +: W] <= head[i*W +: W];
`ifdef SCNTL_TO_SIMD_RESULT_TX_PARITY_EN
          lane_result_parity[i] <= ^head[i*W +: W];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_scntl_to_simd_result_tx.sv
// Scoreboard bench for scntl_to_simd_result_tx.
// Per-lane expected queues are filled on drive and drained on pulses.
module tb_scntl_to_simd_result_tx;

  localparam int NL = 32;
  localparam int W  = 32;

  logic             clk;
  logic             reset_poweron;
  logic             op_start;
  logic [NL-1:0]    op_lane_enable;
  logic [NL-1:0]    stop_result_valid;
  logic [NL*W-1:0]  stop_result_data;
  logic [NL-1:0]    stop_result_ready;
  logic             simd_stall;
  logic [NL-1:0]    lane_result_valid;
  logic [NL*W-1:0]  lane_result;
  logic             op_busy;
  logic             op_complete;
  logic             op_error;
`ifdef SCNTL_TO_SIMD_RESULT_TX_PARITY_EN
  logic [NL-1:0]    stop_result_parity;
  logic [NL-1:0]    lane_result_parity;
  logic [NL-1:0]    par_flip;
  always_comb begin
    for (int i = 0; i < NL; i++)
      stop_result_parity[i] = (^stop_result_data[i*W +: W]) ^ par_flip[i];
  end
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q [NL][$];

  scntl_to_simd_result_tx dut (
    .clk                (clk),
    .reset_poweron      (reset_poweron),
    .op_start           (op_start),
    .op_lane_enable     (op_lane_enable),
    .stop_result_valid  (stop_result_valid),
    .stop_result_data   (stop_result_data),
`ifdef SCNTL_TO_SIMD_RESULT_TX_PARITY_EN
    .stop_result_parity (stop_result_parity),
    .lane_result_parity (lane_result_parity),
`endif
    .stop_result_ready  (stop_result_ready),
    .simd_stall         (simd_stall),
    .lane_result_valid  (lane_result_valid),
    .lane_result        (lane_result),
    .op_busy            (op_busy),
    .op_complete        (op_complete),
    .op_error           (op_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int l, input logic [W-1:0] d);
    stop_result_valid[l]     = 1'b1;
    stop_result_data[l*W +: W] = d;
    exp_q[l].push_back(d);
  endtask

  task automatic wait_complete(input string tag, input int max);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      @(negedge clk);
      if (op_complete) seen = 1'b1;
      else step();
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!reset_poweron) begin
      for (int i = 0; i < NL; i++) begin
        if (lane_result_valid[i]) begin
          if (exp_q[i].size() == 0)
            chk("sb_unexpected", 64'd1, 64'd0);
          else
            chk("sb_data", 64'(lane_result[i*W +: W]),
                64'(exp_q[i].pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pend;
    reset_poweron     = 1'b1;
    op_start          = 1'b0;
    op_lane_enable    = '0;
    stop_result_valid = '0;
    stop_result_data  = '0;
    simd_stall        = 1'b0;
`ifdef SCNTL_TO_SIMD_RESULT_TX_PARITY_EN
    par_flip          = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(stop_result_ready), 64'hFFFF_FFFF);
    chk("rst_valid", 64'(lane_result_valid), 64'd0);
    chk("rst_busy", 64'(op_busy), 64'd0);
    chk("rst_complete", 64'(op_complete), 64'd0);
    chk("rst_error", 64'(op_error), 64'd0);
    reset_poweron = 1'b0;
    step();

    // four lanes return together
    op_start = 1'b1; op_lane_enable = 32'hF;
    step();
    op_start = 1'b0;
    for (int l = 0; l < 4; l++) drive(l, W'((l + 1) * 32'h11));
    step();
    stop_result_valid = '0;
    @(negedge clk);
    chk("t1_valid", 64'(lane_result_valid), 64'hF);
    chk("t1_no_early_cmp", 64'(op_complete), 64'd0);
    step();
    @(negedge clk);
    chk("t1_complete", 64'(op_complete), 64'd1);
    chk("t1_error", 64'(op_error), 64'd0);
    step();
    @(negedge clk);
    chk("t1_idle", 64'(op_busy), 64'd0);

    // stall while lane 2 fills
    step();
    op_start = 1'b1; op_lane_enable = 32'h4;
    step();
    op_start = 1'b0; simd_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(2, 32'hA0 + 32'(k));
      step();
    end
    stop_result_valid = '0;
    @(negedge clk);
    chk("t2_ready_full", 64'(stop_result_ready[2]), 64'd0);
    chk("t2_stall_valid", 64'(lane_result_valid), 64'd0);
    step();
    @(negedge clk);
    chk("t2_stall_valid2", 64'(lane_result_valid), 64'd0);
    step();
    simd_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("t2_pulse", 64'(lane_result_valid[2]), 64'd1);
    end
    step();
    @(negedge clk);
    chk("t2_drained", 64'(lane_result_valid), 64'd0);
    chk("t2_idle", 64'(op_busy), 64'd0);

    // result on a lane outside the mask
    step();
    op_start = 1'b1; op_lane_enable = 32'h1;
    step();
    op_start = 1'b0;
    drive(7, 32'h77);
    step();
    stop_result_valid = '0;
    drive(0, 32'h55);
    step();
    stop_result_valid = '0;
    @(negedge clk);
    chk("t3_error", 64'(op_error), 64'd1);
    wait_complete("t3_complete", 10);

    // empty enable mask
    step();
    op_start = 1'b1; op_lane_enable = '0;
    step();
    op_start = 1'b0;
    @(negedge clk);
    chk("t4_busy1", 64'(op_busy), 64'd1);
    chk("t4_cmp1", 64'(op_complete), 64'd0);
    step();
    @(negedge clk);
    chk("t4_busy2", 64'(op_busy), 64'd1);
    chk("t4_cmp2", 64'(op_complete), 64'd1);
    step();
    @(negedge clk);
    chk("t4_busy3", 64'(op_busy), 64'd0);
    chk("t4_cmp3", 64'(op_complete), 64'd0);

    // async reset mid-DRAIN with 3 entries buffered
    step();
    simd_stall = 1'b1;
    op_start = 1'b1; op_lane_enable = 32'h7;
    drive(0, 32'h101); drive(1, 32'h202); drive(2, 32'h303);
    step();
    op_start = 1'b0; stop_result_valid = '0;
    step();
    @(negedge clk);
    chk("t5_busy", 64'(op_busy), 64'd1);
    #2 reset_poweron = 1'b1;
    #1;
    chk("t5_valid", 64'(lane_result_valid), 64'd0);
    chk("t5_data", 64'(|lane_result), 64'd0);
    chk("t5_busy_rst", 64'(op_busy), 64'd0);
    chk("t5_ready", 64'(stop_result_ready), 64'hFFFF_FFFF);
    chk("t5_error", 64'(op_error), 64'd0);
    for (int i = 0; i < NL; i++) exp_q[i].delete();
    simd_stall = 1'b0;
    step();
    reset_poweron = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("t5_no_stale", 64'(lane_result_valid), 64'd0);
      chk("t5_idle", 64'(op_busy), 64'd0);
    end

`ifdef SCNTL_TO_SIMD_RESULT_TX_PARITY_EN
    step();
    op_start = 1'b1; op_lane_enable = 32'h1;
    step();
    op_start = 1'b0;
    drive(0, 32'h7);
    par_flip[0] = 1'b1;
    step();
    stop_result_valid = '0; par_flip = '0;
    @(negedge clk);
    chk("par_valid", 64'(lane_result_valid[0]), 64'd1);
    chk("par_out", 64'(lane_result_parity[0]), 64'd1);
    chk("par_error", 64'(op_error), 64'd1);
`endif

    repeat (3) step();
    pend = 0;
    for (int i = 0; i < NL; i++) pend += exp_q[i].size();
    chk("sb_empty", 64'(pend), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
